fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 156 +++++++++++++++
 tb/tb_fetch_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end driving the Icache read port.
// Owns the PC, issues fetches, buffers {instruction, PC} pairs for decode,
// and restarts on redirects.
// Optional macro FETCH_PERF_EN adds perf_fetch_cnt / perf_stall_cnt outputs.
module fetch_unit #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] ic_addr,
    output logic        ic_read_en,
    input  logic [31:0] ic_data,
    input  logic        ic_stall,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [63:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_STALL,
        ST_FULL
    } state_e;

    state_e             state_q;
    logic [63:0]        pc_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [31:0]        mem_data_q [FIFO_DEPTH];
    logic [63:0]        mem_pc_q   [FIFO_DEPTH];
    logic               inst_valid_q;
    logic [31:0]        inst_data_q;
    logic [63:0]        inst_pc_q;

    logic               full_c;
    logic               read_en_c;
    logic               push_c;
    logic               pop_c;
    logic [CNT_W-1:0]   count_after_pop_c;
    logic [CNT_W-1:0]   count_d;
    logic [PTR_W-1:0]   rd_ptr_d;

    // Request, push/pop qualification and next occupancy; redirect kills both.
    always_comb begin
        full_c            = (count_q == CNT_W'(FIFO_DEPTH));
        read_en_c         = ((state_q == ST_RUN) || (state_q == ST_STALL))
                            && !redirect_valid && !full_c;
        push_c            = read_en_c && !ic_stall;
        pop_c             = inst_valid_q && inst_ready && !redirect_valid;
        count_after_pop_c = count_q - CNT_W'(pop_c);
        count_d           = count_after_pop_c + CNT_W'(push_c);
        rd_ptr_d          = rd_ptr_q + PTR_W'(pop_c);
    end

    assign ic_addr    = pc_q;
    assign ic_read_en = read_en_c;
    assign inst_valid = inst_valid_q;
    assign inst_data  = inst_data_q;
    assign inst_pc    = inst_pc_q;

    // Buffer storage; entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_data_q[wr_ptr_q] <= ic_data;
            mem_pc_q[wr_ptr_q]   <= pc_q;
        end
    end

    // FSM, PC, buffer pointers and registered head outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_PC;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            inst_valid_q <= 1'b0;
            inst_data_q  <= '0;
            inst_pc_q    <= '0;
        end else if (redirect_valid) begin
            state_q      <= ST_RUN;
            pc_q         <= {redirect_pc[63:2], 2'b00};
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            inst_valid_q <= 1'b0;
        end else begin
            if (push_c) begin
                pc_q     <= pc_q + 64'd4;
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            inst_valid_q <= (count_d != '0);
            // Head comes from the bypassed fetch when the buffer drains to it.
            if (count_d != '0) begin
                if (count_after_pop_c == '0) begin
                    inst_data_q <= ic_data;
                    inst_pc_q   <= pc_q;
                end else begin
                    inst_data_q <= mem_data_q[rd_ptr_d];
                    inst_pc_q   <= mem_pc_q[rd_ptr_d];
                end
            end
            case (state_q)
                ST_BOOT: state_q <= ST_RUN;
                ST_RUN, ST_STALL: begin
                    if (read_en_c && ic_stall)
                        state_q <= ST_STALL;
                    else if (count_d == CNT_W'(FIFO_DEPTH))
                        state_q <= ST_FULL;
                    else
                        state_q <= ST_RUN;
                end
                ST_FULL: if (pop_c) state_q <= ST_RUN;
                default: state_q <= ST_BOOT;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_stall_q;

    // Completed-fetch and stalled-request counters, free-running modulo 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (push_c)
                perf_fetch_q <= perf_fetch_q + 32'd1;
            if (read_en_c && ic_stall)
                perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized traffic checked against a
// queue-based behavioural model of the fetch front end.
module tb_fetch_unit;

    localparam logic [63:0] RST_PC = 64'h100;
    localparam int unsigned DEPTH  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] ic_addr;
    logic        ic_read_en;
    logic [31:0] ic_data;
    logic        ic_stall;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [63:0] inst_pc;
    logic        inst_ready;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .ic_addr        (ic_addr),
        .ic_read_en     (ic_read_en),
        .ic_data        (ic_data),
        .ic_stall       (ic_stall),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic [63:0] pc;
    } ent_t;

    int          checks   = 0;
    int          failures = 0;
    ent_t        q[$];
    logic [63:0] m_pc;
    bit          m_boot;
    logic [31:0] m_hd;
    logic [63:0] m_hpc;
    logic [31:0] m_fcnt;
    logic [31:0] m_scnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc   = RST_PC;
        m_boot = 1'b1;
        m_hd   = '0;
        m_hpc  = '0;
        m_fcnt = '0;
        m_scnt = '0;
    endtask

    // One clock: drive at negedge, check outputs, then advance the model at posedge.
    task automatic step(input bit rv, input logic [63:0] rpc, input bit st,
                        input bit rdy, input logic [31:0] d);
        bit ren;
        bit pop;
        @(negedge clk);
        redirect_valid = rv;
        redirect_pc    = rpc;
        ic_stall       = st;
        inst_ready     = rdy;
        ic_data        = d;
        #1;
        ren = !m_boot && !rv && (q.size() < DEPTH);
        check("read_en", 64'(ic_read_en), 64'(ren));
        check("ic_addr", ic_addr, m_pc);
        check("inst_valid", 64'(inst_valid), 64'(q.size() != 0));
        check("inst_data", 64'(inst_data), 64'(m_hd));
        check("inst_pc", inst_pc, m_hpc);
`ifdef FETCH_PERF_EN
        check("perf_fetch", 64'(perf_fetch_cnt), 64'(m_fcnt));
        check("perf_stall", 64'(perf_stall_cnt), 64'(m_scnt));
`endif
        @(posedge clk);
        if (rv) begin
            m_pc = {rpc[63:2], 2'b00};
            q.delete();
        end else begin
            pop = (q.size() != 0) && rdy;
            if (pop) void'(q.pop_front());
            if (ren && !st) begin
                q.push_back('{d: d, pc: m_pc});
                m_pc   = m_pc + 64'd4;
                m_fcnt = m_fcnt + 32'd1;
            end
            if (ren && st) m_scnt = m_scnt + 32'd1;
        end
        m_boot = 1'b0;
        if (q.size() != 0) begin
            m_hd  = q[0].d;
            m_hpc = q[0].pc;
        end
    endtask

    initial begin
        reset          = 1'b0;
        ic_data        = '0;
        ic_stall       = 1'b0;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Boot cycle then straight-line fetch.
        step(0, '0, 0, 1, 32'hA000_0000);
        step(0, '0, 0, 1, 32'hA000_0001);
        // Stall three cycles at 0x104, then complete.
        repeat (3) step(0, '0, 1, 1, 32'hDEAD_BEEF);
        step(0, '0, 0, 1, 32'hA000_0002);
        // Decode blocked until the buffer fills, then a single pop.
        for (int i = 0; i < 6; i++) step(0, '0, 0, 0, 32'hB000_0000 + 32'(i));
        step(0, '0, 0, 1, 32'hB100_0000);
        step(0, '0, 0, 0, 32'hB200_0000);
        step(0, '0, 0, 0, 32'hB300_0000);
        // Redirect during a stall with entries buffered.
        step(1, 64'h2003, 1, 0, 32'hC000_0000);
        for (int i = 0; i < 4; i++) step(0, '0, 0, 1, 32'hC100_0000 + 32'(i));
        // PC wrap at the top of the address space.
        step(1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1, 32'hD000_0000);
        step(0, '0, 0, 1, 32'hD100_0000);
        step(0, '0, 0, 1, 32'hD200_0000);
        step(0, '0, 0, 1, 32'hD300_0000);
        // Three entries buffered, then a stall, then reset mid-stall.
        step(1, 64'h300, 0, 0, 32'hE000_0000);
        for (int i = 0; i < 3; i++) step(0, '0, 0, 0, 32'hE100_0000 + 32'(i));
        step(0, '0, 1, 0, 32'hE200_0000);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_valid", 64'(inst_valid), 64'd0);
        check("rst_read_en", 64'(ic_read_en), 64'd0);
        check("rst_addr", ic_addr, RST_PC);
        check("rst_inst_pc", inst_pc, 64'd0);
`ifdef FETCH_PERF_EN
        check("rst_perf_stall", 64'(perf_stall_cnt), 64'd0);
`endif
        model_reset();
        ic_stall   = 1'b0;
        inst_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 4; i++) step(0, '0, 0, 1, 32'hF000_0000 + 32'(i));

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            bit          rv;
            logic [63:0] rpc;
            rv  = ($urandom_range(0, 24) == 0);
            rpc = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0)
                rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            step(rv, rpc, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 6, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
